// File: rtl/bool_sweep_pkg.sv
// Shared types and sizes for the 3-input truth-table sweeper and its helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bool_sweep_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int SETTLE_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/bool_sweep_settle_timer.sv
// Loadable settle down-counter; expire is high during the last cycle of a loaded hold time.
// Latency: load at edge N gives expire in cycle N+load_val (load_val >= 1).
// Backpressure: none; clr beats load, load beats counting, counter idles at zero.
module bool_sweep_settle_timer
    import bool_sweep_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                expire
);

    logic [SETTLE_W-1:0] count;

    // Count down from the loaded value and park at zero.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - SETTLE_W'(1);
        end
    end

    // A count of one marks the final cycle of the hold window.
    assign expire = (count == SETTLE_W'(1));

endmodule

// File: rtl/bool3_truth_table_sweeper.sv
// Sweeps a,b,c over all 8 vectors (c fastest), samples d after a settle hold, builds the truth table.
// Latency: SETTLE_CYCLES+1 cycles per vector; done pulses 8*(SETTLE_CYCLES+1)+1 cycles after start is taken.
// Backpressure: start is only honoured in IDLE; the optional expected-table check is enabled by BOOL_SWEEP_CHECK_EN.
module bool3_truth_table_sweeper
    import bool_sweep_pkg::*;
#(
    parameter int unsigned  SETTLE_CYCLES = 2,     // legal range 1..15
    parameter logic [7:0]   EXPECTED      = 8'hEA  // bit i = d for {a,b,c} == i
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       d,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic       match,
    output logic [2:0] err_idx
);

    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_VECTORS - 1);

    state_t                      state;
    logic   [IDX_W-1:0]          idx;
    logic   [IDX_W-1:0]          idx_inc;
    logic   [NUM_VECTORS-1:0]    tt_next;
    logic                        accept;
    logic                        tmr_load;
    logic                        tmr_clr;
    logic                        tmr_expire;

    assign accept  = (state == IDLE) && start;
    assign idx_inc = idx + IDX_W'(1);

    // The timer is restarted for every vector, including the first one as start is taken.
    assign tmr_load = accept || ((state == SAMPLE) && (idx != LAST_IDX));
    assign tmr_clr  = (state == DONE);

    bool_sweep_settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (SETTLE_LD),
        .expire   (tmr_expire)
    );

    // Truth table as it will look after the current SAMPLE cycle closes.
    always_comb begin
        tt_next      = truth_table;
        tt_next[idx] = d;
    end

    // Sweep FSM; every output changes on the same edge as the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            {a, b, c}   <= 3'b000;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SETTLE;
                        idx         <= '0;
                        {a, b, c}   <= 3'b000;
                        busy        <= 1'b1;
                        truth_table <= '0;
                    end
                end
                SETTLE: begin
                    if (tmr_expire) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    truth_table <= tt_next;
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        {a, b, c} <= 3'b000;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state     <= SETTLE;
                        idx       <= idx_inc;
                        {a, b, c} <= idx_inc;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    idx   <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BOOL_SWEEP_CHECK_EN
    logic err_seen;

    // Compare each captured bit against the reference and remember the first miss.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match    <= 1'b0;
            err_idx  <= '0;
            err_seen <= 1'b0;
        end else if (accept) begin
            match    <= 1'b0;
            err_idx  <= '0;
            err_seen <= 1'b0;
        end else if (state == SAMPLE) begin
            if (!err_seen && (d != EXPECTED[idx])) begin
                err_idx  <= idx;
                err_seen <= 1'b1;
            end
            if (idx == LAST_IDX) begin
                match <= (tt_next == EXPECTED);
            end
        end
    end
`else
    // The reference table only matters in the checking build.
    logic unused_expected;
    assign unused_expected = ^EXPECTED;
    assign match           = 1'b0;
    assign err_idx         = '0;
`endif

endmodule

// File: tb/tb_bool3_truth_table_sweeper.sv
// Directed bench for the truth-table sweeper: two instances, default settle and settle of one.
// Latency: n/a.
// Backpressure: n/a.
module tb_bool3_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start1;
    logic       fsel;
    logic       glitch;

    logic       a, b, c, d, busy, done, match;
    logic [7:0] tt;
    logic [2:0] err_idx;

    logic       a1, b1, c1, d1, busy1, done1, match1;
    logic [7:0] tt1;
    logic [2:0] err_idx1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Function blocks under sweep: (a&b)|c or a^b^c, with an optional glitch injector.
    assign d  = (fsel ? (a ^ b ^ c) : ((a & b) | c)) ^ glitch;
    assign d1 = (a1 & b1) | c1;

    bool3_truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(8'hEA)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .d           (d),
        .a           (a),
        .b           (b),
        .c           (c),
        .busy        (busy),
        .done        (done),
        .truth_table (tt),
        .match       (match),
        .err_idx     (err_idx)
    );

    bool3_truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'hEA)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start1),
        .d           (d1),
        .a           (a1),
        .b           (b1),
        .c           (c1),
        .busy        (busy1),
        .done        (done1),
        .truth_table (tt1),
        .match       (match1),
        .err_idx     (err_idx1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sweep on the default instance, starting from IDLE, observed for 30 cycles.
    task automatic sweep0(input string tag, input bit repulse, input bit glitchy,
                          input logic [7:0] want_tt, input bit want_match,
                          input logic [2:0] want_err);
        int   bad;
        int   n_done;
        int   done_cyc;
        logic match_at_done;
        bad = 0; n_done = 0; done_cyc = 0; match_at_done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            start  = repulse && (cyc == 5 || cyc == 12);
            glitch = glitchy && (cyc <= 24) && (cyc % 3 != 0);
            if (cyc <= 24) begin
                if ({a, b, c} !== 3'((cyc - 1) / 3) || busy !== 1'b1) bad++;
            end else begin
                if ({a, b, c} !== 3'b000 || busy !== 1'b0) bad++;
            end
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc == 0) begin
                    done_cyc      = cyc;
                    match_at_done = match;
                end
            end
            tick();
        end
        start  = 1'b0;
        glitch = 1'b0;
        chk({tag, ".vector_seq"}, bad, 0);
        chk({tag, ".done_cycle"}, done_cyc, 25);
        chk({tag, ".done_count"}, n_done, 1);
        chk({tag, ".truth_table"}, tt, want_tt);
`ifdef BOOL_SWEEP_CHECK_EN
        chk({tag, ".match_at_done"}, match_at_done, want_match);
        chk({tag, ".match_held"}, match, want_match);
        chk({tag, ".err_idx"}, err_idx, want_err);
`else
        chk({tag, ".match_tied"}, match_at_done, 1'b0);
        chk({tag, ".err_idx_tied"}, err_idx, 3'd0);
        if (want_match || want_err != 3'd0) n_tests += 0;
`endif
    endtask

    initial begin
        int done_cycles[4];
        int n_done1;
        int act;

        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; fsel = 1'b0; glitch = 1'b0;

        // Reset held three cycles with start low: everything idle and zero.
        act = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({a, b, c, busy, done} !== 5'b0) act++;
        end
        chk("rst.activity", act, 0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.tt", tt, 8'h00);
        chk("rst.match", match, 1'b0);
        chk("rst.err_idx", err_idx, 3'd0);
        chk("rst.dut1_outs", {a1, b1, c1, busy1, done1, tt1, match1, err_idx1}, 16'h0000);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle.abc_busy", {a, b, c, busy}, 4'b0000);

        // Clean sweep of (a&b)|c.
        sweep0("and_or", 1'b0, 1'b0, 8'hEA, 1'b1, 3'd0);

        // XOR function: first disagreement with 0xEA is at vector 2.
        fsel = 1'b1;
        sweep0("xor3", 1'b0, 1'b0, 8'h96, 1'b0, 3'd2);
        fsel = 1'b0;

        // start re-pulsed mid-sweep and d glitching during SETTLE: no effect.
        sweep0("repulse_glitch", 1'b1, 1'b1, 8'hEA, 1'b1, 3'd0);

        // Reset during the first SETTLE cycle of vector 4.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        chk("midrst.vec4", {a, b, c}, 3'd4);
        chk("midrst.partial_tt", tt, 8'h0A);
        rst_n = 1'b0;
        tick();
        chk("midrst.outs", {a, b, c, busy, done, match, err_idx}, 9'h000);
        chk("midrst.tt", tt, 8'h00);
        rst_n = 1'b1;
        tick();
        sweep0("after_rst", 1'b0, 1'b0, 8'hEA, 1'b1, 3'd0);

        // SETTLE_CYCLES=1 instance with start held high: back-to-back sweeps.
        n_done1 = 0;
        for (int i = 0; i < 4; i++) done_cycles[i] = 0;
        start1 = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc == 2) chk("held.abc_c2", {a1, b1, c1}, 3'd0);
            if (cyc == 3) chk("held.abc_c3", {a1, b1, c1}, 3'd1);
            if (cyc == 17) chk("held.tt_at_done", tt1, 8'hEA);
            if (cyc == 18) begin
                chk("held.tt_idle", tt1, 8'hEA);
                chk("held.busy_idle", busy1, 1'b0);
            end
            if (done1 === 1'b1) begin
                if (n_done1 < 4) done_cycles[n_done1] = cyc;
                n_done1++;
            end
            tick();
        end
        start1 = 1'b0;
        repeat (40) tick();
        chk("held.done_count", n_done1, 3);
        chk("held.done_1", done_cycles[0], 17);
        chk("held.done_2", done_cycles[1], 35);
        chk("held.done_3", done_cycles[2], 53);
        chk("held.tt_final", tt1, 8'hEA);
        chk("held.busy_final", busy1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
